// File: rtl/wb_scoreboard_pkg.sv
// wb_scoreboard_pkg: shared widths, register-number type and a write-back match helper
package wb_scoreboard_pkg;
  localparam int REG_NUM_W = 5;
  localparam int NUM_REGS = 32;
  localparam int DATA_W = 32;
  typedef logic [REG_NUM_W-1:0] reg_num_t;
  // True when an enabled write targets register b; r0 never matches.
  function automatic logic wb_hit(logic en, reg_num_t wn, reg_num_t b);
    return en && wn == b && b != '0;
  endfunction
endpackage

// File: rtl/wb_scoreboard_pend_cnt.sv
// pend_cnt: floor-0, ceiling-max up/down counter of in-flight writes to one register
//   clk, rst_n    : clock, synchronous active-low reset
//   inc           : one new writer issued
//   dec_a, dec_b  : writer retired / writer squashed (may coincide)
//   cnt           : current pending count
module pend_cnt #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec_a,
  input  logic             dec_b,
  output logic [CNT_W-1:0] cnt
);
  logic [CNT_W:0] up_d, nxt_d, dn_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    up_d = {1'b0, cnt_q} + (CNT_W+1)'(inc);
    dn_d = (CNT_W+1)'(dec_a) + (CNT_W+1)'(dec_b);
    nxt_d = up_d < dn_d ? '0 : up_d - dn_d;
    cnt_d = nxt_d[CNT_W] ? '1 : nxt_d[CNT_W-1:0];
  end
  always_ff @(posedge clk)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: MEM/WB register, write-back port, pending-write scoreboard, forwarding and RAW stall
//   MEM inputs (mem_*) are registered onto RegWrite/WN/WD; iss_* / kill_* adjust per-register
//   pending counters; RN1/RN2 with RD1/RD2 produce forwarded op1/op2 and the stall flag.
module wb_scoreboard
  import wb_scoreboard_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int CNT_W = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mem_valid,
  input  logic          mem_reg_write,
  input  logic          mem_mem2reg,
  input  logic [4:0]    mem_wn,
  input  logic [DW-1:0] mem_alu,
  input  logic [DW-1:0] mem_ld,
  input  logic          iss_valid,
  input  logic [4:0]    iss_wn,
  input  logic          iss_we,
  output logic          iss_ready,
  input  logic          kill_valid,
  input  logic [4:0]    kill_wn,
  output logic          RegWrite,
  output logic [4:0]    WN,
  output logic [DW-1:0] WD,
  input  logic [4:0]    RN1,
  input  logic [4:0]    RN2,
  input  logic [DW-1:0] RD1,
  input  logic [DW-1:0] RD2,
  output logic [DW-1:0] op1,
  output logic [DW-1:0] op2,
  output logic          stall
);
  logic reg_write_q, reg_write_d;
  reg_num_t wn_q, wn_d;
  logic [DW-1:0] wd_q, wd_d;
  logic [CNT_W-1:0] cnt [NUM_REGS];
  logic [NUM_REGS-1:1] inc, dec_wb, dec_k;
  // A register still has a writer outstanding once the one retiring now is discounted.
  function automatic logic busy(logic [CNT_W-1:0] c, logic retiring);
    return c != '0 && !(c == CNT_W'(1) && retiring);
  endfunction
  always_comb begin
    reg_write_d = mem_valid && mem_reg_write && mem_wn != '0;
    wn_d = mem_wn;
    wd_d = mem_mem2reg ? mem_ld : mem_alu;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      reg_write_q <= 1'b0;
      wn_q <= '0;
      wd_q <= '0;
    end else begin
      reg_write_q <= reg_write_d;
      wn_q <= wn_d;
      wd_q <= wd_d;
    end
  assign RegWrite = reg_write_q;
  assign WN = wn_q;
  assign WD = wd_q;
  // A saturated counter can still accept a new writer when one retires in the same cycle.
  assign iss_ready = !(iss_we && iss_wn != '0 && cnt[iss_wn] == '1 && !wb_hit(reg_write_q, wn_q, iss_wn));
  always_comb
    for (int r = 1; r < NUM_REGS; r++) begin
      inc[r] = iss_valid && iss_we && iss_ready && iss_wn == reg_num_t'(r);
      dec_wb[r] = reg_write_q && wn_q == reg_num_t'(r);
      dec_k[r] = kill_valid && kill_wn == reg_num_t'(r);
    end
  assign cnt[0] = '0;
  for (genvar g = 1; g < NUM_REGS; g++) begin : g_cnt
    pend_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk(clk),
      .rst_n(rst_n),
      .inc(inc[g]),
      .dec_a(dec_wb[g]),
      .dec_b(dec_k[g]),
      .cnt(cnt[g])
    );
  end
  assign op1 = wb_hit(reg_write_q, wn_q, RN1) ? wd_q : RD1;
  assign op2 = wb_hit(reg_write_q, wn_q, RN2) ? wd_q : RD2;
  assign stall = (RN1 != '0 && busy(cnt[RN1], wb_hit(reg_write_q, wn_q, RN1)))
              || (RN2 != '0 && busy(cnt[RN2], wb_hit(reg_write_q, wn_q, RN2)));
endmodule

// File: tb/tb_wb_scoreboard.sv
// tb_wb_scoreboard: directed scenarios plus randomized traffic checked against a queue-free counting model
module tb_wb_scoreboard;
  localparam int MAXC = 3;
  logic clk = 1'b0, rst_n = 1'b0;
  logic mem_valid, mem_reg_write, mem_mem2reg, iss_valid, iss_we, kill_valid;
  logic [4:0] mem_wn, iss_wn, kill_wn, RN1, RN2;
  logic [31:0] mem_alu, mem_ld, RD1, RD2;
  logic iss_ready, RegWrite, stall;
  logic [4:0] WN;
  logic [31:0] WD, op1, op2;
  always #5 clk = ~clk;
  wb_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
    .mem_mem2reg(mem_mem2reg), .mem_wn(mem_wn), .mem_alu(mem_alu), .mem_ld(mem_ld),
    .iss_valid(iss_valid), .iss_wn(iss_wn), .iss_we(iss_we), .iss_ready(iss_ready),
    .kill_valid(kill_valid), .kill_wn(kill_wn), .RegWrite(RegWrite), .WN(WN), .WD(WD),
    .RN1(RN1), .RN2(RN2), .RD1(RD1), .RD2(RD2), .op1(op1), .op2(op2), .stall(stall)
  );
  int checks = 0, errors = 0;
  int cnt_m [32];
  int unsent [32];
  logic wb_we = 1'b0;
  logic [4:0] wb_wn = '0;
  logic [31:0] wb_wd = '0;
  function automatic logic wb_hits(logic [4:0] r);
    return wb_we && wb_wn == r && r != 0;
  endfunction
  function automatic logic exp_ready();
    return !(iss_we && iss_wn != 0 && cnt_m[iss_wn] == MAXC && !wb_hits(iss_wn));
  endfunction
  function automatic logic pend(logic [4:0] r);
    return r != 0 && (cnt_m[r] - (wb_hits(r) ? 1 : 0)) != 0;
  endfunction
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic check_all();
    chk("iss_ready", iss_ready, exp_ready());
    chk("op1", op1, wb_hits(RN1) ? wb_wd : RD1);
    chk("op2", op2, wb_hits(RN2) ? wb_wd : RD2);
    chk("stall", stall, pend(RN1) || pend(RN2));
    chk("RegWrite", RegWrite, wb_we);
    chk("WN", WN, wb_wn);
    chk("WD", WD, wb_wd);
  endtask
  task automatic dec_cnt(input logic [4:0] r);
    if (r == 0) return;
    if (cnt_m[r] == 0) begin
      errors++;
      $display("FAIL underflow: reg %0d decremented at count 0", r);
    end else cnt_m[r]--;
  endtask
  task automatic model_update();
    logic acc;
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) begin
        cnt_m[r] = 0;
        unsent[r] = 0;
      end
      wb_we = 1'b0;
      wb_wn = '0;
      wb_wd = '0;
    end else begin
      acc = iss_valid && iss_we && exp_ready() && iss_wn != 0;
      if (acc) begin
        cnt_m[iss_wn]++;
        unsent[iss_wn]++;
      end
      if (wb_we) dec_cnt(wb_wn);
      if (kill_valid) begin
        dec_cnt(kill_wn);
        if (unsent[kill_wn] > 0) unsent[kill_wn]--;
      end
      if (mem_valid && mem_reg_write && mem_wn != 0 && unsent[mem_wn] > 0) unsent[mem_wn]--;
      wb_we = mem_valid && mem_reg_write && mem_wn != 0;
      wb_wn = mem_wn;
      wb_wd = mem_mem2reg ? mem_ld : mem_alu;
    end
  endtask
  task automatic idle();
    rst_n = 1'b1;
    mem_valid = 0; mem_reg_write = 0; mem_mem2reg = 0; mem_wn = 0; mem_alu = 0; mem_ld = 0;
    iss_valid = 0; iss_we = 0; iss_wn = 0; kill_valid = 0; kill_wn = 0;
    RN1 = 0; RN2 = 0; RD1 = 0; RD2 = 0;
  endtask
  task automatic settle();
    @(negedge clk);
    check_all();
  endtask
  task automatic adv();
    model_update();
    @(posedge clk);
    #1;
  endtask
  task automatic cyc();
    settle();
    adv();
  endtask
  task automatic issue(input logic [4:0] r);
    iss_valid = 1; iss_we = 1; iss_wn = r;
  endtask
  task automatic mem_wr(input logic [4:0] r, input logic m2r, input logic [31:0] alu, input logic [31:0] ld);
    mem_valid = 1; mem_reg_write = 1; mem_wn = r; mem_mem2reg = m2r; mem_alu = alu; mem_ld = ld;
  endtask
  task automatic do_reset();
    idle(); rst_n = 0; cyc(); idle();
  endtask
  initial begin
    idle();
    rst_n = 0;
    @(posedge clk); #1;
    adv();
    idle();
    settle();
    chk("rst_RegWrite", RegWrite, 0);
    chk("rst_WN", WN, 0);
    chk("rst_WD", WD, 0);
    adv();
    idle(); issue(5); RN1 = 5; settle();
    chk("t1_ready", iss_ready, 1); chk("t1_nostall", stall, 0); adv();
    idle(); RN1 = 5; mem_wr(5, 0, 32'h1234, 32'h5555); settle();
    chk("t1_stall", stall, 1); adv();
    idle(); RN1 = 5; RD1 = 32'hBAD0; settle();
    chk("t1_RegWrite", RegWrite, 1); chk("t1_WN", WN, 5); chk("t1_WD", WD, 32'h1234);
    chk("t1_op1", op1, 32'h1234); chk("t1_wb_nostall", stall, 0); adv();
    idle(); issue(9); cyc();
    idle(); mem_wr(9, 1, 32'h1, 32'hDEADBEEF); cyc();
    idle(); settle();
    chk("t2_RegWrite", RegWrite, 1); chk("t2_WD", WD, 32'hDEADBEEF); adv();
    idle(); issue(0); mem_wr(0, 0, 32'h99, 32'h0); RN1 = 0; RD1 = 32'h77; settle();
    chk("t3_stall", stall, 0); chk("t3_op1", op1, 32'h77); adv();
    idle(); RN1 = 0; RD1 = 32'h77; settle();
    chk("t3_RegWrite", RegWrite, 0); chk("t3_op1b", op1, 32'h77); adv();
    for (int i = 0; i < 3; i++) begin idle(); issue(7); cyc(); end
    idle(); issue(7); RN1 = 7; settle();
    chk("t4_full", iss_ready, 0); chk("t4_stall", stall, 1); adv();
    idle(); mem_wr(7, 0, 32'h7, 32'h0); cyc();
    idle(); issue(7); settle();
    chk("t4_retire_ready", iss_ready, 1); adv();
    idle(); issue(7); settle();
    chk("t4_still_full", iss_ready, 0); adv();
    do_reset();
    idle(); issue(3); cyc();
    idle(); kill_valid = 1; kill_wn = 3; RN2 = 3; settle();
    chk("t5_stall_before_kill", stall, 1); adv();
    idle(); RN2 = 3; settle();
    chk("t5_kill_clears", stall, 0); adv();
    idle(); issue(3); cyc();
    idle(); issue(3); cyc();
    idle(); mem_wr(3, 0, 32'h33, 32'h0); cyc();
    idle(); kill_valid = 1; kill_wn = 3; RN2 = 3; settle();
    chk("t5_wb", RegWrite, 1); chk("t5_stall2", stall, 1); adv();
    idle(); RN2 = 3; settle();
    chk("t5_double_dec", stall, 0); adv();
    idle(); issue(4); cyc();
    idle(); issue(4); cyc();
    idle(); mem_wr(4, 0, 32'h44, 32'h0); cyc();
    idle(); rst_n = 0; RN1 = 4; settle();
    chk("t6_RegWrite_pre", RegWrite, 1); chk("t6_stall_pre", stall, 1); adv();
    idle(); RN1 = 4; settle();
    chk("t6_RegWrite_post", RegWrite, 0); chk("t6_stall_post", stall, 0); adv();
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] r;
      idle();
      rst_n = ($urandom_range(99) != 0);
      iss_valid = 1'($urandom_range(1));
      iss_we = 1'($urandom_range(1));
      iss_wn = 5'($urandom_range(7));
      r = 5'($urandom_range(7, 1));
      if ($urandom_range(3) == 0 && unsent[r] > 0) begin
        kill_valid = 1; kill_wn = r;
      end
      mem_valid = 1'($urandom_range(1));
      mem_reg_write = 1'($urandom_range(1));
      mem_mem2reg = 1'($urandom_range(1));
      mem_wn = 5'($urandom_range(7));
      mem_alu = $urandom;
      mem_ld = $urandom;
      if (mem_valid && mem_reg_write && mem_wn != 0
          && unsent[mem_wn] - ((kill_valid && kill_wn == mem_wn) ? 1 : 0) <= 0) mem_reg_write = 0;
      RN1 = 5'($urandom_range(7));
      RN2 = 5'($urandom_range(7));
      RD1 = $urandom;
      RD2 = $urandom;
      cyc();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
